c4_turn_controller: RTL
=======================

// Module: c4_turn_controller
// PURPOSE
//  Game sequencer for Connect Four: turns the three button inputs into cursor moves and
//  piece drops, tracks per-column fill heights, issues a board-write handshake, then runs
//  the win checker, alternates players and detects win/draw. Sits inside connect_four_top
//  between the button conditioning and the board RAM, win checker and VGA renderer.
// PARAMETERS
//  COLS   7  board columns; cursor range 0..COLS-1
//  ROWS   6  board rows; row 0 = bottom
//  COL_W  3  width of column index
//  ROW_W  3  width of row index / height counter
// PORTS
//  clk_25MHz   in   1      system clock; every register updates on its rising edge
//  rst         in   1      synchronous reset, active-high
//  move_right  in   1      right button, level, already synchronised and debounced
//  move_left   in   1      left button, level, already synchronised and debounced
//  drop_piece  in   1      drop button / restart after game over; level
//  cursor_col  out  COL_W  column currently selected, for the renderer
//  cur_player  out  1      0 = player 1, 1 = player 2; player whose turn it is
//  wr_req      out  1      board write request; held until wr_ack
//  wr_col      out  COL_W  write column; stable while wr_req=1
//  wr_row      out  ROW_W  write row (= height of column before the drop)
//  wr_player   out  1      owner of the piece being written
//  wr_ack      in   1      board RAM accepted the write; sampled only while wr_req=1
//  chk_start   out  1      one-cycle pulse: start win check around (wr_col, wr_row)
//  chk_done    in   1      win checker finished; sampled only in CHECK
//  chk_win     in   1      valid with chk_done: last piece completed four in a row
//  board_clr   out  1      one-cycle pulse: clear board RAM (restart)
//  game_over   out  1      high in OVER state
//  winner      out  2      00 none, 01 player 1, 10 player 2, 11 draw
// BEHAVIOUR
//  - Reset: state IDLE, cursor_col=COLS/2 (3), cur_player=0, all heights=0, move_count=0,
//    wr_req=0, chk_start=0, board_clr=0, game_over=0, winner=00; previous-button regs
//    reset to 1, so a button held through reset does not register as a press.
//  - Press = input high while its previous-cycle sample was low. Presses are acted on only
//    in IDLE (drop also in OVER); all others are discarded, never queued.
//  - All outputs are registered: an action taken at edge N is visible after edge N.
//  - IDLE priority: drop > move. Drop press with heights[cursor]<ROWS: latch wr_col=cursor,
//    wr_row=heights[cursor], wr_player=cur_player, assert wr_req, go WRITE; cursor
//    moves in the same cycle are ignored. Drop on a full column is ignored (no change).
//  - Right and left pressed together -> no move. Right at COLS-1 wraps to 0; left at 0
//    wraps to COLS-1.
//  - WRITE: wr_req and wr_* held constant until wr_ack=1 is sampled; that cycle
//    wr_req->0, heights[wr_col]++, move_count++, chk_start=1 for exactly one cycle,
//    go CHECK. No timeout; ack may arrive the cycle after wr_req rises.
//  - CHECK: wait for chk_done. chk_win=1 -> OVER, winner = cur_player?10:01.
//    Else move_count==COLS*ROWS -> OVER, winner=11. Else toggle cur_player, go IDLE.
//    chk_done in the same cycle as chk_start is ignored; only the next cycle on counts.
//  - OVER: game_over=1; cursor frozen. Drop press -> board_clr pulses one cycle, all
//    state returns to reset values (prev-button regs excepted), go IDLE.
//  - rst in any state (mid-WRITE included) overrides everything, no write completes;
//    board_clr is not pulsed by rst (the board RAM has its own reset).
//  - Heights saturate at ROWS by construction; move_count is 6 bits, never exceeds 42.
// TESTING
//  1 Reset, right pressed 4x (1-cycle-high pulses) -> cursor 3,4,5,6,0; left once -> 6.
//  2 Drop at col 3, wr_ack 2 cycles later -> wr_req held 2 cycles with col=3,row=0,
//    player=0; chk_start one pulse; chk_done=1,chk_win=0 -> cur_player=1, IDLE.
//  3 Fill col 0 with 6 drops, 7th drop at col 0 -> no wr_req, player unchanged.
//  4 Vertical four for P1 with chk_win=1 on 4th check -> game_over=1, winner=01;
//    right/left ignored; drop -> board_clr one cycle, cursor=3, winner=00, player 0.
//  5 42 non-winning drops -> winner=11 after 42nd chk_done; drop restarts game.
//  6 rst while wr_req=1 -> next cycle wr_req=0, heights unchanged; drop held through rst
//    gives no press until released and pressed again.

Source files
------------

// File: rtl/c4_turn_controller.sv
// Connect Four turn sequencer: cursor movement, piece drops, board-write handshake,
// win-check sequencing, player alternation and win/draw detection.
module c4_turn_controller #(
    parameter int COLS  = 7,
    parameter int ROWS  = 6,
    parameter int COL_W = 3,
    parameter int ROW_W = 3
) (
    input  logic             clk_25MHz,
    input  logic             rst,
    input  logic             move_right,
    input  logic             move_left,
    input  logic             drop_piece,
    output logic [COL_W-1:0] cursor_col,
    output logic             cur_player,
    output logic             wr_req,
    output logic [COL_W-1:0] wr_col,
    output logic [ROW_W-1:0] wr_row,
    output logic             wr_player,
    input  logic             wr_ack,
    output logic             chk_start,
    input  logic             chk_done,
    input  logic             chk_win,
    output logic             board_clr,
    output logic             game_over,
    output logic [1:0]       winner
);

    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0] HOME_COL  = COL_W'(COLS / 2);
    localparam logic [COL_W-1:0] COL_ONE   = COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_LIMIT = ROW_W'(ROWS);
    localparam logic [ROW_W-1:0] ROW_ONE   = ROW_W'(1);
    localparam logic [5:0]       CELLS     = 6'(COLS * ROWS);
    localparam logic [5:0]       CNT_ONE   = 6'(1);

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StCheck,
        StOver
    } state_e;

    state_e           state_q;
    logic [ROW_W-1:0] heights_q [COLS];
    logic [5:0]       move_count_q;
    logic             prev_right_q;
    logic             prev_left_q;
    logic             prev_drop_q;

    logic             right_press;
    logic             left_press;
    logic             drop_press;
    logic [ROW_W-1:0] cur_height;
    logic [COL_W-1:0] cursor_right;
    logic [COL_W-1:0] cursor_left;

    assign right_press  = move_right & ~prev_right_q;
    assign left_press   = move_left & ~prev_left_q;
    assign drop_press   = drop_piece & ~prev_drop_q;
    assign cur_height   = heights_q[cursor_col];
    assign cursor_right = (cursor_col == LAST_COL) ? '0 : cursor_col + COL_ONE;
    assign cursor_left  = (cursor_col == '0) ? LAST_COL : cursor_col - COL_ONE;

    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            state_q      <= StIdle;
            cursor_col   <= HOME_COL;
            cur_player   <= 1'b0;
            move_count_q <= '0;
            for (int i = 0; i < COLS; i++) begin
                heights_q[i] <= '0;
            end
            wr_req       <= 1'b0;
            wr_col       <= '0;
            wr_row       <= '0;
            wr_player    <= 1'b0;
            chk_start    <= 1'b0;
            board_clr    <= 1'b0;
            game_over    <= 1'b0;
            winner       <= 2'b00;
            // Buttons held through reset must be released before they count as presses.
            prev_right_q <= 1'b1;
            prev_left_q  <= 1'b1;
            prev_drop_q  <= 1'b1;
        end else begin
            prev_right_q <= move_right;
            prev_left_q  <= move_left;
            prev_drop_q  <= drop_piece;
            chk_start    <= 1'b0;
            board_clr    <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (drop_press) begin
                        if (cur_height < ROW_LIMIT) begin
                            wr_col    <= cursor_col;
                            wr_row    <= cur_height;
                            wr_player <= cur_player;
                            wr_req    <= 1'b1;
                            state_q   <= StWrite;
                        end
                    end else if (right_press && !left_press) begin
                        cursor_col <= cursor_right;
                    end else if (left_press && !right_press) begin
                        cursor_col <= cursor_left;
                    end
                end

                StWrite: begin
                    if (wr_ack) begin
                        wr_req            <= 1'b0;
                        heights_q[wr_col] <= heights_q[wr_col] + ROW_ONE;
                        move_count_q      <= move_count_q + CNT_ONE;
                        chk_start         <= 1'b1;
                        state_q           <= StCheck;
                    end
                end

                StCheck: begin
                    // A done flag alongside our own start pulse is stale; ignore it.
                    if (chk_done && !chk_start) begin
                        if (chk_win) begin
                            winner    <= cur_player ? 2'b10 : 2'b01;
                            game_over <= 1'b1;
                            state_q   <= StOver;
                        end else if (move_count_q == CELLS) begin
                            winner    <= 2'b11;
                            game_over <= 1'b1;
                            state_q   <= StOver;
                        end else begin
                            cur_player <= ~cur_player;
                            state_q    <= StIdle;
                        end
                    end
                end

                StOver: begin
                    if (drop_press) begin
                        state_q      <= StIdle;
                        cursor_col   <= HOME_COL;
                        cur_player   <= 1'b0;
                        move_count_q <= '0;
                        for (int i = 0; i < COLS; i++) begin
                            heights_q[i] <= '0;
                        end
                        wr_req       <= 1'b0;
                        wr_col       <= '0;
                        wr_row       <= '0;
                        wr_player    <= 1'b0;
                        game_over    <= 1'b0;
                        winner       <= 2'b00;
                        board_clr    <= 1'b1;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
